// File: rtl/hazard_pkg.sv
// Shared decode constants and the multiply-occupancy state type
// for the pipeline interlock controller.
package hazard_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic {
      IDLE,
      BUSY
   } mul_state_t;

endpackage

// File: rtl/mul_stall_ctr.sv
// Tracks how long a multi-cycle multiply has occupied EX.
// Raises the stall for every cycle except the last.
module mul_stall_ctr
   import hazard_pkg::*;
#(
   parameter int MULT_LATENCY = 3
) (
   input  logic clk,
   input  logic arst_n,
   input  logic mul_ex,
   output logic mul_stall
);

   localparam int CNT_W = $clog2(MULT_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY - 1);
   localparam logic MULTI_CYCLE = (MULT_LATENCY > 1);

   mul_state_t state;
   logic [CNT_W-1:0] cnt;

   // The MUL stays held in EX while stalled, so BUSY counts cycles without
   // re-checking the instruction; a following MUL is seen afresh in IDLE.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mul_ex && MULTI_CYCLE) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(1);
               end
            end
            BUSY: begin
               if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      mul_stall = 1'b0;
      if (arst_n) begin
         case (state)
            IDLE:    mul_stall = mul_ex && MULTI_CYCLE;
            BUSY:    mul_stall = (cnt != CNT_LAST);
            default: mul_stall = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock controller: multiply stall, taken-branch flush and
// load-use bubble, plus a saturating count of front-end stall cycles.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MULT_LATENCY = 3,
   parameter int COUNT_W      = 32
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic [31:0]        instruction_ID,
   input  logic [31:0]        instruction_EX,
   input  logic               MemRead_EX,
   input  logic               branch_taken_EX,
   output logic               pc_write_en,
   output logic               if_id_write_en,
   output logic               id_ex_write_en,
   output logic               flush_if_id,
   output logic               flush_id_ex,
   output logic               flush_ex_mem,
   output logic               mul_busy,
   output logic [COUNT_W-1:0] stall_count
);

   logic [4:0] rd_ex;
   logic [4:0] rs1_id;
   logic [4:0] rs2_id;
   logic       mul_ex;
   logic       mul_stall;
   logic       load_use;
   logic       unused_bits;

   assign rd_ex  = instruction_EX[11:7];
   assign rs1_id = instruction_ID[19:15];
   assign rs2_id = instruction_ID[24:20];
   assign mul_ex = (instruction_EX[6:0] == OPC_OP) && (instruction_EX[31:25] == F7_MULDIV);

   // rs fields are compared for every format; a false match only costs a bubble.
   assign load_use = MemRead_EX && (rd_ex != 5'd0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));

   assign unused_bits = ^{instruction_ID[31:25], instruction_ID[14:0], instruction_EX[24:12]};

   mul_stall_ctr #(
      .MULT_LATENCY(MULT_LATENCY)
   ) u_mul_stall_ctr (
      .clk      (clk),
      .arst_n   (arst_n),
      .mul_ex   (mul_ex),
      .mul_stall(mul_stall)
   );

   // Priority: multiply hold, then taken branch (which discards the ID
   // instruction and so any load-use on it), then load-use bubble.
   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_ex_write_en = 1'b1;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_ex_mem   = 1'b0;
      mul_busy       = 1'b0;
      if (arst_n) begin
         if (mul_stall) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            flush_ex_mem   = 1'b1;
            mul_busy       = 1'b1;
         end else if (branch_taken_EX) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            flush_id_ex    = 1'b1;
         end
      end
   end

   // Performance counter holds at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_count <= '0;
      end else if (!pc_write_en && (stall_count != '1)) begin
         stall_count <= stall_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios then random traffic,
// checked against a cycle-level reference model for latencies 3 and 1.
module tb_hazard_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        arst_n;
   logic [31:0] instruction_ID;
   logic [31:0] instruction_EX;
   logic        MemRead_EX;
   logic        branch_taken_EX;

   logic        pc3, ifid3, idex3, fifid3, fidex3, fexmem3, mbusy3;
   logic [31:0] cnt3_dut;
   logic        pc1, ifid1, idex1, fifid1, fidex1, fexmem1, mbusy1;
   logic [31:0] cnt1_dut;

   typedef struct {
      logic [6:0]  o3;
      logic [31:0] c3;
      logic [6:0]  o1;
      logic [31:0] c1;
   } exp_t;

   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   int occ3 = 0;
   int occ1 = 0;
   int cnt3 = 0;
   int cnt1 = 0;
   logic stim_done = 1'b0;

   hazard_unit #(.MULT_LATENCY(3), .COUNT_W(32)) u_dut (
      .clk(clk), .arst_n(arst_n),
      .instruction_ID(instruction_ID), .instruction_EX(instruction_EX),
      .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
      .pc_write_en(pc3), .if_id_write_en(ifid3), .id_ex_write_en(idex3),
      .flush_if_id(fifid3), .flush_id_ex(fidex3), .flush_ex_mem(fexmem3),
      .mul_busy(mbusy3), .stall_count(cnt3_dut)
   );

   hazard_unit #(.MULT_LATENCY(1), .COUNT_W(32)) u_dut_l1 (
      .clk(clk), .arst_n(arst_n),
      .instruction_ID(instruction_ID), .instruction_EX(instruction_EX),
      .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
      .pc_write_en(pc1), .if_id_write_en(ifid1), .id_ex_write_en(idex1),
      .flush_if_id(fifid1), .flush_id_ex(fidex1), .flush_ex_mem(fexmem1),
      .mul_busy(mbusy1), .stall_count(cnt1_dut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] load_w(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'd0, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   // Outputs packed as {pc, if_id, id_ex, flush_if_id, flush_id_ex, flush_ex_mem, mul_busy}.
   // occ = cycles the current MUL still occupies EX after this one.
   function automatic logic [6:0] model(input int lat, input logic rstn, input logic [31:0] iid,
                                        input logic [31:0] iex, input logic mr, input logic br,
                                        inout int occ);
      logic is_mul, stall, lu;
      logic [4:0] rd;
      if (!rstn) begin
         occ = 0;
         return 7'b1110000;
      end
      is_mul = (iex[6:0] == 7'b0110011) && (iex[31:25] == 7'b0000001);
      stall  = 1'b0;
      if (occ > 0) begin
         stall = (occ > 1);
         occ   = occ - 1;
      end else if (is_mul && lat > 1) begin
         stall = 1'b1;
         occ   = lat - 1;
      end
      rd = iex[11:7];
      lu = mr && (rd != 5'd0) && (rd == iid[19:15] || rd == iid[24:20]);
      if (stall)   return 7'b0000011;
      if (br)      return 7'b1111100;
      if (lu)      return 7'b0010100;
      return 7'b1110000;
   endfunction

   task automatic applyStimulus(input logic rstn, input logic [31:0] iid, input logic [31:0] iex,
                                input logic mr, input logic br);
      exp_t e;
      @(posedge clk);
      #1;
      arst_n          = rstn;
      instruction_ID  = iid;
      instruction_EX  = iex;
      MemRead_EX      = mr;
      branch_taken_EX = br;
      if (!rstn) begin
         cnt3 = 0;
         cnt1 = 0;
      end
      e.c3 = cnt3;
      e.c1 = cnt1;
      e.o3 = model(3, rstn, iid, iex, mr, br, occ3);
      e.o1 = model(1, rstn, iid, iex, mr, br, occ1);
      if (!e.o3[6] && cnt3 != 32'hFFFFFFFF) cnt3++;
      if (!e.o1[6] && cnt1 != 32'hFFFFFFFF) cnt1++;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [6:0] a3, a1;
      a3 = {pc3, ifid3, idex3, fifid3, fidex3, fexmem3, mbusy3};
      a1 = {pc1, ifid1, idex1, fifid1, fidex1, fexmem1, mbusy1};
      checks += 4;
      if (a3 !== e.o3) begin
         errors++;
         $display("[TB] FAIL ctrl_lat3 t=%0t got=%b expected=%b", $time, a3, e.o3);
      end
      if (cnt3_dut !== e.c3) begin
         errors++;
         $display("[TB] FAIL count_lat3 t=%0t got=%0d expected=%0d", $time, cnt3_dut, e.c3);
      end
      if (a1 !== e.o1) begin
         errors++;
         $display("[TB] FAIL ctrl_lat1 t=%0t got=%b expected=%b", $time, a1, e.o1);
      end
      if (cnt1_dut !== e.c1) begin
         errors++;
         $display("[TB] FAIL count_lat1 t=%0t got=%0d expected=%0d", $time, cnt1_dut, e.c1);
      end
   endtask

   // Monitor: outputs are combinational, so each queued cycle is valid at the following negedge.
   always @(negedge clk) begin
      if (sb.size() > 0) checkOutput(sb.pop_front());
   end

   initial begin
      logic [31:0] mul_a, mul_b, add_dep, prev_ex, iid, iex;
      logic mr, br;
      int kind;

      arst_n = 1'b0;
      instruction_ID = NOP;
      instruction_EX = NOP;
      MemRead_EX = 1'b0;
      branch_taken_EX = 1'b0;

      mul_a   = r_type(7'b0000001, 5'd2, 5'd1, 5'd3);
      mul_b   = r_type(7'b0000001, 5'd4, 5'd3, 5'd8);
      add_dep = r_type(7'b0000000, 5'd7, 5'd5, 5'd6);

      applyStimulus(1'b0, NOP, NOP, 1'b0, 1'b0);
      applyStimulus(1'b0, add_dep, mul_a, 1'b1, 1'b1);
      applyStimulus(1'b1, NOP, NOP, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, NOP, 1'b0, 1'b0);

      // Load-use bubble, then the load moves on and a bubble sits in EX.
      applyStimulus(1'b1, add_dep, load_w(5'd5, 5'd1), 1'b1, 1'b0);
      applyStimulus(1'b1, add_dep, NOP, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, add_dep, 1'b0, 1'b0);

      // Load into x0 never stalls.
      applyStimulus(1'b1, r_type(7'b0, 5'd0, 5'd0, 5'd6), load_w(5'd0, 5'd1), 1'b1, 1'b0);

      // Single MUL held in EX, then two back-to-back MULs.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, NOP, mul_a, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, NOP, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, NOP, mul_a, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, NOP, mul_b, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, NOP, 1'b0, 1'b0);

      // Taken branch overrides a load-use pair.
      applyStimulus(1'b1, add_dep, load_w(5'd5, 5'd1), 1'b1, 1'b1);

      // Reset during the second BUSY cycle, then a clean restart.
      applyStimulus(1'b1, NOP, mul_a, 1'b0, 1'b0);
      applyStimulus(1'b0, NOP, mul_a, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, NOP, 1'b0, 1'b0);
      applyStimulus(1'b1, add_dep, NOP, 1'b0, 1'b0);

      prev_ex = NOP;
      for (int n = 0; n < 600; n++) begin
         iid = r_type(7'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
         mr  = 1'b0;
         if (occ3 > 0) begin
            iex = prev_ex;
         end else begin
            kind = $urandom_range(0, 3);
            case (kind)
               0:       iex = NOP;
               1: begin
                  iex = load_w(5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
                  mr  = 1'b1;
               end
               2:       iex = r_type(7'b0000001, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
               default: iex = r_type(7'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            endcase
         end
         br = ($urandom_range(0, 5) == 0);
         prev_ex = iex;
         applyStimulus(($urandom_range(0, 49) != 0), iid, iex, mr, br);
      end
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      wait (stim_done);
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain pending=%0d expected=0", sb.size());
      end
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline interlock controller for the 5-stage RISC-V core, the stalling counterpart of the EX-stage forwarding unit. Forwarding covers every dependency it can bypass; this block covers the rest. It stalls the front end when a load result is needed in the next cycle, and holds the pipeline while a multi-cycle multiply occupies EX. It also flushes IF/ID and ID/EX on a taken branch. It sits beside the pipeline registers and drives their write-enable and flush controls.

## Interface
- MULT_LATENCY, 3, total cycles a MUL-class instruction occupies EX; must be at least 1.
- COUNT_W, 32, width of the stall-cycle performance counter.

- clk  in  1  system clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- instruction_ID  in  32  instruction in ID.
- instruction_EX  in  32  instruction in EX.
- MemRead_EX  in  1  EX instruction is a load.
- branch_taken_EX  in  1  EX branch/jump resolved taken.
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID register enable.
- id_ex_write_en  out  1  ID/EX register enable.
- flush_if_id  out  1  load NOP into IF/ID.
- flush_id_ex  out  1  load NOP (bubble) into ID/EX.
- flush_ex_mem  out  1  load NOP into EX/MEM.
- mul_busy  out  1  multiply stall active this cycle.
- stall_count  out  COUNT_W  saturating count of cycles in which pc_write_en was 0.

## Operation
Field decode:
- rd_EX = instruction_EX[11:7].
- rs1_ID = instruction_ID[19:15].
- rs2_ID = instruction_ID[24:20].
- mul_EX = (instruction_EX[6:0] == 7'b0110011) and (instruction_EX[31:25] == 7'b0000001).

States:
- IDLE: if mul_EX and MULT_LATENCY > 1, raise the mul stall, set cnt <= 1 and go to BUSY. Otherwise no mul stall.
- BUSY: mul stall = (cnt != MULT_LATENCY-1).
  - If cnt == MULT_LATENCY-1: go to IDLE and clear cnt; the MUL leaves EX this cycle.
  - Else: cnt <= cnt+1.
- Result: each MUL causes exactly MULT_LATENCY-1 stall cycles. A back-to-back MUL is detected afresh in IDLE.

Conditions, highest priority first:
- Mul stall: pc_write_en=0, if_id_write_en=0, id_ex_write_en=0, flush_ex_mem=1, mul_busy=1. Branch and load-use are ignored.
- Branch taken (no mul stall): flush_if_id=1, flush_id_ex=1, write enables 1. Load-use is suppressed because the ID instruction is discarded.
- Load-use: MemRead_EX and rd_EX != 0 and (rd_EX == rs1_ID or rd_EX == rs2_ID).
  - Response: pc_write_en=0, if_id_write_en=0, flush_id_ex=1, id_ex_write_en=1.
  - The rs fields are compared regardless of format (conservative).
- None of the above: all write enables 1, all flushes 0.

stall_count increments on every clock edge where pc_write_en is 0, and saturates at all-ones.

## Timing
- All outputs are combinational from the current inputs, state and cnt. There is no output register.
- Load-use stall lasts exactly 1 cycle; the forwarding unit then supplies the load data from WB.
- Reset (arst_n low): state = IDLE, cnt = 0, stall_count = 0. Outputs are forced to pc/if_id/id_ex write enable 1, all flushes 0, mul_busy 0, independent of the inputs.
- Reset asserted mid-BUSY: the block returns to IDLE immediately. The pipeline registers reset too, so no stale stall remains.
- MULT_LATENCY = 1: BUSY is never entered and mul_busy is never asserted.

## Structure
- Shared package hazard_pkg contains:
  - opcode constant OPC_OP = 7'b0110011.
  - constant F7_MULDIV = 7'b0000001.
  - state enum {IDLE, BUSY}.
- One sub-module, mul_stall_ctr, holds the state, cnt (width $clog2(MULT_LATENCY)+1) and the mul stall output.
- The top level holds the decode, the priority mux and stall_count.

## Test plan
- Reset release with NOP instructions: all write enables 1, all flushes 0, stall_count 0.
- Load x5 in EX (MemRead_EX=1), add x6,x5,x7 in ID: one cycle with pc_write_en=0 and flush_id_ex=1, then normal flow. stall_count = 1.
- Load x0 in EX, consumer of x0 in ID: no stall.
- mul x3,x1,x2 held in EX with MULT_LATENCY=3: mul_busy and flush_ex_mem high for exactly 2 cycles, write enables 0, released on the 3rd cycle.
- Two consecutive MULs: 2 stall cycles, 1 release cycle, then 2 more stall cycles. stall_count = 4.
- branch_taken_EX=1 with a load-use pair present: flush_if_id=1, flush_id_ex=1, pc_write_en=1.
- arst_n low on the 2nd BUSY cycle: outputs return to defaults immediately; after release, no residual stall.
